waiting_ack_buffer: RTL
=======================

Name: waiting_ack_buffer

Overview:
Retransmission store sitting directly upstream of the tx buffer selector. It feeds the selector's waiting-ack input.
- Accepts data flits from the cpu_to_noc path.
- Presents each flit for transmission and then holds it until a matching ack arrives.
- On timeout it re-offers the flit, and after the retry limit it drops the flit and reports it.

Parameters:
DEPTH, 4, number of slots (power of two, >=2)
ID_WIDTH, 8, width of the flit identifier used for ack matching
TIMEOUT, 256, cycles spent in WAITING before retransmit (>=2)
MAX_RETRY, 3, retransmissions allowed before the flit is dropped

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
flit_in  input  types::flit_t  flit to store
flit_in_id  input  ID_WIDTH  identifier of flit_in
flit_in_valid  input  1  flit_in is valid
flit_in_ready  output  1  a FREE slot exists
flit_out  output  types::flit_t  flit offered to the selector
flit_out_valid  output  1  a PENDING slot exists
flit_out_ready  input  1  selector takes flit_out this cycle
ack_valid  input  1  ack received
ack_id  input  ID_WIDTH  identifier carried by the ack
drop_valid  output  1  one-cycle pulse: a flit was dropped
drop_id  output  ID_WIDTH  identifier of the dropped flit
occupancy  output  $clog2(DEPTH)+1  number of non-FREE slots

Behaviour:
- Reset:
  - All slots FREE; timers and retry counts are 0.
  - flit_out_valid=0, flit_out=0, drop_valid=0, drop_id=0, occupancy=0, flit_in_ready=1.
  - A reset asserted mid-operation discards all contents; no drop pulse is emitted.
- Per-slot state is FREE, PENDING or WAITING. Each slot holds a flit, an id, a timer of $clog2(TIMEOUT) bits and a retry count of $clog2(MAX_RETRY+1) bits.
- Accept:
  - flit_in_ready is derived from registered state only; a slot freed this cycle is not usable until the next cycle.
  - On flit_in_valid&flit_in_ready, the lowest-index FREE slot becomes PENDING with retry=0 next cycle.
  - Accept-to-offer latency is 1 cycle.
- Offer:
  - flit_out and flit_out_valid are combinational from registered state.
  - The lowest-index PENDING slot is presented.
  - flit_out is 0 when flit_out_valid=0.
- Send: on flit_out_valid&flit_out_ready, the presented slot becomes WAITING with timer=0.
- Timer:
  - In WAITING the timer increments every cycle.
  - When timer==TIMEOUT-1 and no ack: if retry<MAX_RETRY, retry++ and the slot returns to PENDING.
  - Otherwise the slot becomes FREE and drop_valid=1, drop_id=slot id, both registered (next cycle).
- Ack:
  - On ack_valid, every PENDING or WAITING slot whose id==ack_id becomes FREE next cycle.
  - An unmatched ack is ignored.
  - An ack does not match a flit accepted in the same cycle.
- Simultaneous events:
  - Ack and send of the same slot: FREE.
  - Ack and timeout of the same slot: FREE, no drop, no retransmit.
  - Several timeouts in one cycle: the lowest index drops this cycle; the others hold at TIMEOUT-1 and are processed on later cycles, so at most one drop pulse per cycle.
  - Accept and send in the same cycle touch different slots and are both performed.
- Full/empty:
  - With all slots non-FREE, flit_in_ready=0.
  - With no PENDING slot, flit_out_valid=0.
- occupancy is registered and reflects the post-update slot states.
- Duplicate ids in flight are a protocol violation and are not checked.

Optional Feature:
WAITING_ACK_BUFFER_STATS_EN
- Defined:
  - Adds output retx_count (16 bits), incremented on each timeout-to-PENDING transition and saturating at 0xFFFF.
  - Adds output drop_count (16 bits), incremented on each drop pulse and saturating at 0xFFFF.
  - Both counters reset to 0.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Accept id 0x11 with flit_out_ready=1, then ack 0x11 at cycle 5 -> send 1 cycle after accept; FREE at cycle 6; occupancy 1->0; no retransmit.
- Accept id 0x22 with ack withheld (TIMEOUT=8, MAX_RETRY=3) -> 4 sends spaced 9 cycles apart, then drop_valid=1 with drop_id=0x22 for exactly 1 cycle; occupancy returns to 0.
- Fill 4 slots (ids 1-4) with flit_out_ready=0 -> flit_in_ready=0; ack id 3 -> flit_in_ready=1 the next cycle; a new flit lands in slot 2.
- Ack id 0x33 in the same cycle its timer hits TIMEOUT-1 -> slot FREE, no drop, no resend.
- Assert rst with 3 slots WAITING -> next cycle occupancy=0, flit_out_valid=0, drop_valid=0.
- With WAITING_ACK_BUFFER_STATS_EN, run the second scenario -> retx_count=3, drop_count=1.

Source files
------------

// File: rtl/waiting_ack_buffer.sv
// Retransmission store ahead of the tx buffer selector: offers each flit, holds it until acked,
// re-offers on timeout and drops after MAX_RETRY. Optional counters: WAITING_ACK_BUFFER_STATS_EN.

package types;
   typedef logic [31:0] flit_t;
endpackage

module waiting_ack_buffer_slot #(
   parameter int ID_WIDTH  = 8,
   parameter int TIMEOUT   = 256,
   parameter int MAX_RETRY = 3
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                send,
   input  types::flit_t        flit_in,
   input  logic [ID_WIDTH-1:0] flit_in_id,
   input  logic                ack_valid,
   input  logic [ID_WIDTH-1:0] ack_id,
   input  logic                drop_gnt,
   output logic                busy,
   output logic                pending,
   output logic                timeout,
   output logic                at_max,
   output logic                nxt_busy,
   output types::flit_t        flit,
   output logic [ID_WIDTH-1:0] id
);
   localparam int TW = $clog2(TIMEOUT);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [1:0] {FREE, PENDING, WAITING} st_t;

   st_t           st, st_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [RW-1:0] retry, retry_nxt;
   logic          ack_hit, expired;

   assign ack_hit  = ack_valid && (st != FREE) && (id == ack_id);
   assign expired  = (st == WAITING) && (timer == TW'(TIMEOUT - 1));
   assign timeout  = expired && !ack_hit;
   assign at_max   = (retry >= RW'(MAX_RETRY));
   assign busy     = (st != FREE);
   assign pending  = (st == PENDING);
   assign nxt_busy = (st_nxt != FREE);

   always_comb begin
      st_nxt    = st;
      timer_nxt = timer;
      retry_nxt = retry;
      case (st)
         FREE: if (load) begin
            st_nxt    = PENDING;
            timer_nxt = '0;
            retry_nxt = '0;
         end
         PENDING: if (ack_hit) begin
            st_nxt = FREE;
         end else if (send) begin
            st_nxt    = WAITING;
            timer_nxt = '0;
         end
         WAITING: if (ack_hit) begin
            st_nxt = FREE;
         end else if (expired) begin
            // an expired slot that loses drop arbitration parks at TIMEOUT-1
            if (!at_max) begin
               st_nxt    = PENDING;
               retry_nxt = retry + RW'(1);
            end else if (drop_gnt) begin
               st_nxt = FREE;
            end
         end else begin
            timer_nxt = timer + TW'(1);
         end
         default: st_nxt = FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= FREE;
         timer <= '0;
         retry <= '0;
         flit  <= '0;
         id    <= '0;
      end else begin
         st    <= st_nxt;
         timer <= timer_nxt;
         retry <= retry_nxt;
         if (load) begin
            flit <= flit_in;
            id   <= flit_in_id;
         end
      end
   end
endmodule

module waiting_ack_buffer #(
   parameter int DEPTH     = 4,
   parameter int ID_WIDTH  = 8,
   parameter int TIMEOUT   = 256,
   parameter int MAX_RETRY = 3
)(
   input  logic                     clk,
   input  logic                     rst,
   input  types::flit_t             flit_in,
   input  logic [ID_WIDTH-1:0]      flit_in_id,
   input  logic                     flit_in_valid,
   output logic                     flit_in_ready,
   output types::flit_t             flit_out,
   output logic                     flit_out_valid,
   input  logic                     flit_out_ready,
   input  logic                     ack_valid,
   input  logic [ID_WIDTH-1:0]      ack_id,
   output logic                     drop_valid,
   output logic [ID_WIDTH-1:0]      drop_id,
   output logic [$clog2(DEPTH):0]   occupancy
`ifdef WAITING_ACK_BUFFER_STATS_EN
   ,
   output logic [15:0]              retx_count,
   output logic [15:0]              drop_count
`endif
);
   localparam int IW = $clog2(DEPTH);

   logic [DEPTH-1:0]               busy, pending, timeout, at_max, nxt_busy;
   logic [DEPTH-1:0]               load, send, drop_req, drop_gnt;
   logic [DEPTH-1:0][ID_WIDTH-1:0] slot_id;
   types::flit_t [DEPTH-1:0]       slot_flit;
   logic [IW-1:0]                  acc_idx, off_idx, drp_idx;
   logic                           acc, snd, drp;
   logic [IW:0]                    occ_nxt;

   // descending scan so the lowest matching index wins
   always_comb begin
      acc_idx = '0;
      off_idx = '0;
      drp_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i])    acc_idx = IW'(i);
         if (pending[i])  off_idx = IW'(i);
         if (drop_req[i]) drp_idx = IW'(i);
      end
   end

   assign flit_in_ready  = ~&busy;
   assign acc            = flit_in_valid && flit_in_ready;
   assign flit_out_valid = |pending;
   assign flit_out       = flit_out_valid ? slot_flit[off_idx] : '0;
   assign snd            = flit_out_valid && flit_out_ready;
   assign drop_req       = timeout & at_max;
   assign drp            = |drop_req;

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      assign load[i]     = acc && (acc_idx == IW'(i));
      assign send[i]     = snd && (off_idx == IW'(i));
      assign drop_gnt[i] = drp && (drp_idx == IW'(i));

      waiting_ack_buffer_slot #(
         .ID_WIDTH  (ID_WIDTH),
         .TIMEOUT   (TIMEOUT),
         .MAX_RETRY (MAX_RETRY)
      ) u_slot (
         .clk        (clk),
         .rst        (rst),
         .load       (load[i]),
         .send       (send[i]),
         .flit_in    (flit_in),
         .flit_in_id (flit_in_id),
         .ack_valid  (ack_valid),
         .ack_id     (ack_id),
         .drop_gnt   (drop_gnt[i]),
         .busy       (busy[i]),
         .pending    (pending[i]),
         .timeout    (timeout[i]),
         .at_max     (at_max[i]),
         .nxt_busy   (nxt_busy[i]),
         .flit       (slot_flit[i]),
         .id         (slot_id[i])
      );
   end

   always_comb begin
      occ_nxt = '0;
      for (int i = 0; i < DEPTH; i++)
         occ_nxt = occ_nxt + {{IW{1'b0}}, nxt_busy[i]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_valid <= 1'b0;
         drop_id    <= '0;
         occupancy  <= '0;
      end else begin
         drop_valid <= drp;
         drop_id    <= drp ? slot_id[drp_idx] : '0;
         occupancy  <= occ_nxt;
      end
   end

`ifdef WAITING_ACK_BUFFER_STATS_EN
   logic [DEPTH-1:0] retx;
   logic [15:0]      retx_nxt;

   assign retx = timeout & ~at_max;

   always_comb begin
      retx_nxt = retx_count;
      for (int i = 0; i < DEPTH; i++)
         if (retx[i] && retx_nxt != 16'hFFFF) retx_nxt = retx_nxt + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         retx_count <= '0;
         drop_count <= '0;
      end else begin
         retx_count <= retx_nxt;
         if (drp && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
   end
`endif
endmodule
